// File: rtl/display_pkg.sv
// Shared types and defaults for the display source selector.
package display_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_HOLD   = 2'd2
  } mode_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N_CH  = 4;

endpackage

// File: rtl/display_source_sel_tick_counter.sv
// Enable-gated modulo-TC counter; tc is high during the enabled cycle whose edge wraps the count.
module tick_counter #(
  parameter int TC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CNT_W = (TC > 1) ? $clog2(TC) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(TC - 1));
  assign tc     = en && at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_source_sel.sv
// Registered display-source selector: manual SEL, auto-cycling on a dwell timer, freeze/hold.
// Optional blanking blink enabled by defining DISPLAY_BLINK_EN.
module display_source_sel
  import display_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int N_CH       = DEF_N_CH,
  parameter int DWELL      = 4,
  parameter int BLINK_HALF = 8,
  localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_CH*WIDTH-1:0] SRC_DATA,
  input  logic [CW-1:0]         SEL,
  input  logic                  AUTO,
  input  logic                  FREEZE,
`ifdef DISPLAY_BLINK_EN
  input  logic                  BLINK_REQ,
`endif
  output logic [WIDTH-1:0]      SALIDA,
  output logic [CW-1:0]         CUR_CH,
  output logic [1:0]            MODE
);

  mode_t            state_q, state_d;
  logic [CW-1:0]    cur_ch_q, cur_ch_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             dwell_en, dwell_clr, dwell_tc;

  // Out-of-range indices select nothing and therefore display zero.
  function automatic logic [WIDTH-1:0] pick(input logic [CW-1:0] idx,
                                            input logic [N_CH*WIDTH-1:0] src);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(idx) == k) r = src[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  tick_counter #(.TC(DWELL)) u_dwell (
    .clk  (CLK),
    .rst_n(RESET),
    .en   (dwell_en),
    .clr  (dwell_clr),
    .tc   (dwell_tc)
  );

  // Leaving HOLD with AUTO high behaves as a normal auto cycle, so the dwell count resumes.
  always_comb begin
    state_d   = state_q;
    cur_ch_d  = cur_ch_q;
    val_d     = val_q;
    dwell_en  = 1'b0;
    dwell_clr = 1'b0;
    if (FREEZE) begin
      state_d = MODE_HOLD;
    end else if (state_q == MODE_MANUAL && AUTO) begin
      state_d   = MODE_AUTO;
      cur_ch_d  = '0;
      dwell_clr = 1'b1;
      val_d     = pick('0, SRC_DATA);
    end else if (AUTO) begin
      state_d  = MODE_AUTO;
      val_d    = pick(cur_ch_q, SRC_DATA);
      dwell_en = 1'b1;
      if (dwell_tc) begin
        cur_ch_d = (cur_ch_q == CW'(N_CH - 1)) ? '0 : cur_ch_q + 1'b1;
      end
    end else begin
      state_d  = MODE_MANUAL;
      cur_ch_d = SEL;
      val_d    = pick(SEL, SRC_DATA);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= MODE_MANUAL;
      cur_ch_q <= '0;
      val_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      val_q    <= val_d;
    end
  end

  assign CUR_CH = cur_ch_q;
  assign MODE   = state_q;

`ifdef DISPLAY_BLINK_EN
  logic blink_tc;
  logic phase_q, phase_d;
  logic blank_q, blank_d;

  tick_counter #(.TC(BLINK_HALF)) u_blink (
    .clk  (CLK),
    .rst_n(RESET),
    .en   (1'b1),
    .clr  (1'b0),
    .tc   (blink_tc)
  );

  // Blanking is kept apart from val_q so a held value survives the blank phase.
  always_comb begin
    phase_d = phase_q ^ blink_tc;
    blank_d = BLINK_REQ & phase_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      phase_q <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      blank_q <= blank_d;
    end
  end

  assign SALIDA = blank_q ? '0 : val_q;
`else
  assign SALIDA = val_q;
`endif

endmodule

// File: tb/tb_display_source_sel.sv
// Directed-vector bench for display_source_sel (WIDTH=16, N_CH=4, DWELL=4, BLINK_HALF=8).
module tb_display_source_sel;

  localparam int WIDTH = 16;
  localparam int N_CH  = 4;
  localparam int CW    = 2;

  logic                  clk;
  logic                  reset;
  logic [N_CH*WIDTH-1:0] src_data;
  logic [CW-1:0]         sel;
  logic                  auto_i;
  logic                  freeze;
  logic [WIDTH-1:0]      salida;
  logic [CW-1:0]         cur_ch;
  logic [1:0]            mode;
`ifdef DISPLAY_BLINK_EN
  logic                  blink_req;
`endif

  logic [WIDTH-1:0] ch [N_CH];
  logic [WIDTH-1:0] base [N_CH];
  logic [WIDTH-1:0] exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  assign src_data = {ch[3], ch[2], ch[1], ch[0]};

  display_source_sel #(
    .WIDTH(WIDTH), .N_CH(N_CH), .DWELL(4), .BLINK_HALF(8)
  ) dut (
    .CLK     (clk),
    .RESET   (reset),
    .SRC_DATA(src_data),
    .SEL     (sel),
    .AUTO    (auto_i),
    .FREEZE  (freeze),
`ifdef DISPLAY_BLINK_EN
    .BLINK_REQ(blink_req),
`endif
    .SALIDA  (salida),
    .CUR_CH  (cur_ch),
    .MODE    (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [WIDTH-1:0] s,
                           input logic [CW-1:0] c, input logic [1:0] m);
    check_eq({tag, ".salida"}, 32'(salida), 32'(s));
    check_eq({tag, ".cur_ch"}, 32'(cur_ch), 32'(c));
    check_eq({tag, ".mode"},   32'(mode),   32'(m));
  endtask

  initial begin
    base[0] = 16'h1111; base[1] = 16'h2222; base[2] = 16'h3333; base[3] = 16'h4444;
    for (int k = 0; k < N_CH; k++) ch[k] = base[k];
    reset = 1'b0; auto_i = 1'b1; freeze = 1'b1; sel = 2'd3;
`ifdef DISPLAY_BLINK_EN
    blink_req = 1'b0;
`endif
    step();
    check_out("reset", 16'h0000, 2'd0, 2'd0);

    reset = 1'b1; auto_i = 1'b0; freeze = 1'b0; sel = 2'd2;
    step();
    check_out("man_sel2", 16'h3333, 2'd2, 2'd0);
    sel = 2'd1;
    step();
    check_out("man_sel1", 16'h2222, 2'd1, 2'd0);
    sel = 2'd3;
    step();
    check_out("man_sel3", 16'h4444, 2'd3, 2'd0);

    // Auto entry edge, then edges n=1..22: cur_ch = (n/4)%4, salida = ch[((n-1)/4)%4].
    auto_i = 1'b1;
    step();
    check_out("auto_entry", 16'h1111, 2'd0, 2'd1);
    for (int n = 1; n <= 22; n++) begin
      exp_q.push_back(base[((n - 1) / 4) % 4]);
    end
    for (int n = 1; n <= 22; n++) begin
      step();
      check_eq($sformatf("auto_n%0d.salida", n), 32'(salida), 32'(exp_q.pop_front()));
      check_eq($sformatf("auto_n%0d.cur_ch", n), 32'(cur_ch), (n / 4) % 4);
    end

    // Now cur_ch=1 with dwell count 2.
    freeze = 1'b1;
    step();
    check_out("freeze", 16'h2222, 2'd1, 2'd2);
    ch[1] = 16'hBEEF;
    step();
    check_out("hold_src_chg", 16'h2222, 2'd1, 2'd2);
    freeze = 1'b0;
    step();
    check_out("release", 16'hBEEF, 2'd1, 2'd1);
    step();
    check_out("resume_adv", 16'hBEEF, 2'd2, 2'd1);
    step();
    check_out("resume_live", 16'h3333, 2'd2, 2'd1);
    ch[1] = base[1];

    auto_i = 1'b0; sel = 2'd0;
    step();
    check_out("auto_to_man", 16'h1111, 2'd0, 2'd0);
    auto_i = 1'b1; freeze = 1'b1;
    step();
    check_out("sim_freeze_auto", 16'h1111, 2'd0, 2'd2);
    reset = 1'b0;
    step();
    check_out("reset_in_hold", 16'h0000, 2'd0, 2'd0);

    reset = 1'b1; auto_i = 1'b0; freeze = 1'b0; sel = 2'd3;
    step();
    check_out("man_after_rst", 16'h4444, 2'd3, 2'd0);
    freeze = 1'b1; sel = 2'd0; ch[3] = 16'h5A5A;
    step();
    check_out("man_hold", 16'h4444, 2'd3, 2'd2);
    freeze = 1'b0;
    step();
    check_out("hold_to_man", 16'h1111, 2'd0, 2'd0);
    ch[3] = base[3];

    auto_i = 1'b1;
    step();
    check_out("auto_entry2", 16'h1111, 2'd0, 2'd1);
    step();
    auto_i = 1'b0; sel = 2'd2;
    step();
    check_out("auto_exit_sel", 16'h3333, 2'd2, 2'd0);

`ifdef DISPLAY_BLINK_EN
    begin
      int zeros;
      zeros = 0;
      sel = 2'd3; blink_req = 1'b1;
      step();
      step();
      for (int i = 0; i < 32; i++) begin
        step();
        if (salida == 16'h0000) zeros++;
        else check_eq("blink_val", 32'(salida), 32'h4444);
      end
      check_eq("blink_zero_count", 32'(zeros), 32'd16);
      blink_req = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_source_sel.md
# display_source_sel

Registered, parametrised display-source selector for the calculator datapath. It sits between the operand/result registers and the 7-segment driver. It picks one of N_CH WIDTH-bit channels for SALIDA, either from an external SEL index or by auto-cycling through the channels on a dwell timer. A freeze mode holds the shown value while the sources keep changing.

## Interface
Parameters:
- WIDTH, 16, bit width of each channel and of SALIDA
- N_CH, 4, number of source channels (≥1)
- DWELL, 4, cycles each channel is shown in auto mode (≥1)
- BLINK_HALF, 8, blink half-period in cycles (only used with DISPLAY_BLINK_EN)

Ports:
- CLK  in  1  single clock, rising edge
- RESET  in  1  reset, synchronous, active-low
- SRC_DATA  in  N_CH*WIDTH  flattened sources; channel k at bits [k*WIDTH +: WIDTH]
- SEL  in  CW  manual channel index; CW = max(1, $clog2(N_CH))
- AUTO  in  1  level; request auto-cycle mode
- FREEZE  in  1  level; hold current output
- SALIDA  out  WIDTH  registered displayed value
- CUR_CH  out  CW  channel currently displayed
- MODE  out  2  current state (mode_t encoding)

## Operation
- **Reset** (RESET=0 at an edge):
  - SALIDA=0, CUR_CH=0, MODE=MANUAL.
  - Dwell counter cleared; blink counter and phase cleared.
  - Reset wins over every other input, in every state.
- **Priority each cycle:** reset > FREEZE > AUTO > manual.
- **MANUAL:**
  - CUR_CH<=SEL.
  - SALIDA<=channel SEL, or 0 if SEL≥N_CH.
  - FREEZE=1 → HOLD, outputs unchanged.
  - Else AUTO=1 → AUTO with CUR_CH<=0, counter<=0, SALIDA<=channel 0.
- **AUTO:**
  - SALIDA<=channel CUR_CH every cycle (live tracking).
  - Counter counts 0..DWELL-1. At DWELL-1: counter<=0 and CUR_CH<=CUR_CH+1, wrapping N_CH-1→0.
  - SALIDA always shows the CUR_CH value from before the edge.
  - AUTO=0 → MANUAL, which tracks SEL at that same edge.
  - FREEZE=1 → HOLD.
- **HOLD:**
  - SALIDA, CUR_CH and the counter are frozen; source changes are ignored.
  - FREEZE=0 with AUTO=1 → AUTO; the counter resumes from its held value, not from 0.
  - FREEZE=0 with AUTO=0 → MANUAL.
- **Boundary cases:**
  - N_CH=1: CUR_CH stays 0.
  - DWELL=1: CUR_CH advances every cycle.
  - SEL out of range only affects MANUAL.

## Timing
- 1-cycle latency from SEL/SRC_DATA to SALIDA in MANUAL and AUTO.
- MODE, CUR_CH and SALIDA all update on the same edge.
- FREEZE takes effect at the first edge it is sampled high: SALIDA keeps the value it had before that edge.
- After HOLD is released, the display tracks live data again one edge later.
- Auto dwell is exactly DWELL cycles per channel; a full rotation is N_CH*DWELL cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: DISPLAY_BLINK_EN.
- **Defined:**
  - Adds input port BLINK_REQ (1 bit).
  - A free-running counter toggles a phase bit every BLINK_HALF cycles.
  - When BLINK_REQ=1 and phase=1, SALIDA is forced to 0 (blank). Otherwise SALIDA is as above.
  - The blink counter is not affected by FREEZE.
  - Use case: flag overflow or error results.
- **Undefined:** no BLINK_REQ port, no blink counter, SALIDA is never blanked.

## Structure
- Package display_pkg:
  - typedef enum logic [1:0] mode_t {MODE_MANUAL=0, MODE_AUTO=1, MODE_HOLD=2}.
  - Default localparams for WIDTH and N_CH.
- Sub-module tick_counter, parametrised by terminal count:
  - Inputs: enable and clear.
  - Output: 1-cycle terminal-count pulse.
  - Instantiated for the dwell timer and, under DISPLAY_BLINK_EN, for the blink timer.

## Test plan
Bench settings: WIDTH=16, N_CH=4, DWELL=4, BLINK_HALF=8. Channels ch0..ch3 = 0x1111, 0x2222, 0x3333, 0x4444.
- Reset: hold RESET=0 for one edge with AUTO=1, FREEZE=1 → SALIDA=0x0000, CUR_CH=0, MODE=0.
- Manual: SEL=2 → next edge SALIDA=0x3333, CUR_CH=2. SEL=1 → next edge SALIDA=0x2222.
- Auto rotation: AUTO=1 → SALIDA shows 0x1111, 0x2222, 0x3333, 0x4444 for 4 cycles each, then wraps to 0x1111.
- Freeze mid-dwell:
  - FREEZE=1 at CUR_CH=1, count=2, then change ch1 to 0xBEEF → SALIDA stays 0x2222, MODE=2.
  - Release FREEZE → next edge SALIDA=0xBEEF; CUR_CH→2 after 2 more cycles.
- Simultaneous events:
  - FREEZE and AUTO rise together in MANUAL → MODE=HOLD.
  - RESET=0 while in HOLD → SALIDA=0, MODE=MANUAL next edge.
- Blink (DISPLAY_BLINK_EN defined): BLINK_REQ=1 in MANUAL with SEL=3 → SALIDA alternates 0x4444 / 0x0000 every 8 cycles.
